// File: rtl/chan_mux_pkg.sv
// rtl/chan_mux_pkg.sv - shared encodings and pointer helper for chan_mux_rr
package chan_mux_pkg;

   localparam logic MODE_MANUAL = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

   // Round-robin pointer moves one past the winner, wrapping at the last channel.
   function automatic int unsigned next_ptr(input int unsigned g, input int unsigned n_ch);
      return (g == n_ch - 1) ? 32'd0 : g + 32'd1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational cyclic priority search starting at ptr
module rr_pick #(
   parameter int N_CH = 4,
   localparam int SW = $clog2(N_CH)
) (
   input  logic [N_CH-1:0] req,
   input  logic [SW-1:0]   ptr,
   output logic            gnt_vld,
   output logic [SW-1:0]   gnt_idx
);

   logic [SW-1:0] idx;

   // Walk from the far end so the request nearest ptr is assigned last and wins.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      idx     = '0;
      for (int k = N_CH - 1; k >= 0; k--) begin
         idx = SW'((int'(ptr) + k) % N_CH);
         if (req[idx]) begin
            gnt_vld = 1'b1;
            gnt_idx = idx;
         end
      end
   end

endmodule

// File: rtl/chan_mux_rr.sv
// rtl/chan_mux_rr.sv - N-channel registered mux with manual or round-robin grant
module chan_mux_rr
   import chan_mux_pkg::*;
#(
   parameter int N_CH = 4,
   parameter int W    = 8,
   localparam int SW  = $clog2(N_CH)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [N_CH*W-1:0]   in_data,
   input  logic [N_CH-1:0]     in_valid,
   output logic [N_CH-1:0]     in_ready,
   input  logic                mode,
   input  logic [SW-1:0]       sel,
   output logic [W-1:0]        out_data,
   output logic [SW-1:0]       out_ch,
   output logic                out_valid,
   input  logic                out_ready
);

   logic [W-1:0]  out_data_q, out_data_d;
   logic [SW-1:0] out_ch_q, out_ch_d;
   logic          out_valid_q, out_valid_d;
   logic [SW-1:0] ptr_q, ptr_d;

   logic          load_en;
   logic          scan_vld;
   logic [SW-1:0] scan_idx;
   logic          man_vld;
   logic          gnt_vld;
   logic [SW-1:0] gnt_idx;
   logic          xfer;
   logic [W-1:0]  win_data;

   rr_pick #(.N_CH(N_CH)) u_pick (
      .req     (in_valid),
      .ptr     (ptr_q),
      .gnt_vld (scan_vld),
      .gnt_idx (scan_idx)
   );

   always_comb begin
      load_en = !out_valid_q || out_ready;

      // An out-of-range sel matches no channel, so it can never grant.
      man_vld = 1'b0;
      for (int i = 0; i < N_CH; i++) begin
         if (sel == SW'(i) && in_valid[i]) man_vld = 1'b1;
      end

      if (mode == MODE_SCAN) begin
         gnt_vld = scan_vld;
         gnt_idx = scan_idx;
      end else begin
         gnt_vld = man_vld;
         gnt_idx = sel;
      end

      xfer     = rst_n && load_en && gnt_vld;
      in_ready = '0;
      win_data = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (gnt_idx == SW'(i)) begin
            win_data    = in_data[i*W +: W];
            in_ready[i] = xfer;
         end
      end

      out_data_d  = out_data_q;
      out_ch_d    = out_ch_q;
      out_valid_d = out_valid_q;
      ptr_d       = ptr_q;
      if (xfer) begin
         out_data_d  = win_data;
         out_ch_d    = gnt_idx;
         out_valid_d = 1'b1;
         if (mode == MODE_SCAN) ptr_d = SW'(next_ptr(32'(gnt_idx), N_CH));
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_data_q  <= '0;
         out_ch_q    <= '0;
         out_valid_q <= 1'b0;
         ptr_q       <= '0;
      end else begin
         out_data_q  <= out_data_d;
         out_ch_q    <= out_ch_d;
         out_valid_q <= out_valid_d;
         ptr_q       <= ptr_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_ch    = out_ch_q;
   assign out_valid = out_valid_q;

endmodule

// File: doc/chan_mux_rr.md
# chan_mux_rr

Parametrised N-channel, W-bit registered multiplexer with valid/ready handshakes on every input and on the output. It selects either a fixed channel (manual mode) or the next ready channel in round-robin order (scan mode), and it holds the winning word in a single output register. It is the successor to the team's fixed 4:1 combinational mux. It sits between several producer streams and one shared consumer.

## Interface
- N_CH, 4, number of input channels (≥2; non-power-of-2 allowed)
- W, 8, data width per channel
- SW, $clog2(N_CH), select/channel-index width (derived, not overridden)

- clk  in  1  rising-edge clock, single clock domain
- rst_n  in  1  reset, synchronous, active-low
- in_data  in  N_CH*W  packed channel data, channel i at [i*W +: W]
- in_valid  in  N_CH  per-channel valid
- in_ready  out  N_CH  per-channel ready (combinational from state + inputs)
- mode  in  1  0 = manual (use sel), 1 = round-robin scan
- sel  in  SW  manual channel select
- out_data  out  W  registered output word
- out_ch  out  SW  channel index the current out_data came from
- out_valid  out  1  output register holds a word
- out_ready  in  1  consumer accepts out_data

## Operation
- load_en = !out_valid | out_ready: the output register can take a word this cycle.
- Grant selection, manual mode (mode=0):
  - grant = sel when in_valid[sel]=1 and sel < N_CH.
  - Otherwise there is no grant.
  - sel ≥ N_CH never grants and never asserts any in_ready.
- Grant selection, scan mode (mode=1):
  - grant = lowest index i such that in_valid[i]=1, searching cyclically from ptr (ptr, ptr+1, … N_CH-1, 0, … ptr-1).
  - If no in_valid bit is set, there is no grant.
- in_ready[i] = load_en & granted & (grant == i). At most one in_ready is high.
- A transfer on channel g (in_valid[g] & in_ready[g]) loads the output register:
  - out_data ← in_data[g]
  - out_ch ← g
  - out_valid ← 1
- If out_valid & out_ready and there is no transfer, then out_valid ← 0. out_data and out_ch hold their values.
- Round-robin pointer ptr (SW bits, internal):
  - On a scan-mode transfer on channel g: ptr ← (g == N_CH-1) ? 0 : g+1.
  - Manual-mode transfers leave ptr unchanged.
- mode and sel are sampled every cycle; a change affects the next grant. ptr is not cleared on a mode change.
- Inputs may drop in_valid without a transfer; the block places no hold requirement on producers.

## Timing
- Reset (rst_n=0 at a clk edge) drives: out_valid=0, out_data=0, out_ch=0, ptr=0.
- While rst_n=0, all in_ready=0. Reset mid-transfer discards the held word.
- Latency is 1 cycle: a word accepted at edge k is on out_data with out_valid=1 after edge k.
- Throughput is 1 word/cycle while out_ready=1 and some channel is granted.
- Simultaneous drain and load in the same cycle:
  - out_valid stays 1.
  - The new word replaces the old one.
  - There is no bubble.
- Backpressure: while out_valid=1 and out_ready=0, out_data, out_ch and out_valid stay stable and all in_ready=0.
- Wrap-around: ptr steps N_CH-1 → 0. With N_CH=3, SW=2, ptr never holds 3.
- There are no combinational paths from out_ready to out_data. There is a combinational path from out_ready to in_ready via load_en, and it is documented for integrators.

## Structure
- Package chan_mux_pkg holds:
  - mode encodings: MODE_MANUAL=1'b0, MODE_SCAN=1'b1
  - a helper function for the next-pointer wrap
- Sub-module rr_pick (parameter N_CH):
  - inputs: req[N_CH], ptr[SW]
  - outputs: gnt_vld, gnt_idx[SW]
  - purely combinational cyclic priority search
- chan_mux_rr instantiates rr_pick and owns the output register, ptr and handshake logic.

## Test plan
- Reset:
  - Stimulus: rst_n=0 for 2 cycles with all in_valid=1.
  - Required: out_valid=0, out_data=0, out_ch=0 and in_ready=0 throughout.
- Manual mode:
  - Stimulus: N_CH=4, W=8, mode=0, sel=2, in_data ch2=8'hA5, in_valid=4'b0100, out_ready=1.
  - Required: in_ready=4'b0100, and one cycle later out_data=A5, out_ch=2.
  - Then set sel=1 with in_valid[1]=0. Required: no in_ready, and out_valid falls after a drain.
- Round-robin:
  - Stimulus: mode=1, in_valid=4'b1111 held, out_ready=1, ch i data = 8'h10+i.
  - Required: out_ch sequence 0,1,2,3,0 on consecutive cycles, with out_data 10,11,12,13,10.
- Skip and wrap:
  - Stimulus: mode=1, ptr=3, in_valid=4'b0010.
  - Required: grant on channel 1; ptr becomes 2.
  - Then in_valid=4'b1001. Required: grant on channel 3 (cyclic from 2), then ptr=0.
- Backpressure:
  - Stimulus: a word is held, out_ready=0 for 3 cycles with channels valid.
  - Required: out_data stable and in_ready=0 on all 3 cycles.
  - Then out_ready=1. Required: the next word loads in the same cycle as the drain (out_valid stays 1).
- Non-power-of-2:
  - Stimulus: N_CH=3, mode=0, sel=3.
  - Required: no in_ready.
  - Then mode=1 with all valid. Required: out_ch sequence 0,1,2,0.
